// File: rtl/serial_parity_frame_checker.sv
// Serial parity frame checker: assembles DATA_BITS data bits plus one parity bit
// per frame, checks even/odd parity, and keeps a saturating error count.
module serial_parity_frame_checker #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 odd_mode,
  input  logic                 clear_cnt,
  output logic                 busy,
  output logic                 running_even,
  output logic                 frame_done,
  output logic                 frame_ok,
  output logic [DATA_BITS-1:0] frame_data,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned CntW = $clog2(DATA_BITS + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(DATA_BITS - 1);

  typedef enum logic [1:0] {StIdle, StData, StPar} state_e;

  state_e                 state_q;
  logic [CntW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   mode_q;
  logic                   ones_odd;
  logic                   parity_ok;

  // running_even already reflects the data bits, so only the parity bit is folded in here.
  always_comb begin
    ones_odd  = ~running_even ^ in_bit;
    parity_ok = mode_q ? ones_odd : ~ones_odd;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      mode_q       <= 1'b0;
      busy         <= 1'b0;
      running_even <= 1'b1;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
      frame_data   <= '0;
      err_count    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (clear_cnt) begin
        err_count <= '0;
      end
      if (in_valid) begin
        unique case (state_q)
          StIdle, StData: begin
            for (int unsigned i = 0; i < DATA_BITS; i++) begin
              if (bit_cnt_q == CntW'(i)) begin
                shift_q[i] <= in_bit;
              end
            end
            if (state_q == StIdle) begin
              mode_q <= odd_mode;
            end
            if (in_bit) begin
              running_even <= ~running_even;
            end
            busy      <= 1'b1;
            bit_cnt_q <= bit_cnt_q + CntW'(1);
            state_q   <= (bit_cnt_q == LastIdx) ? StPar : StData;
          end
          StPar: begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            busy         <= 1'b0;
            running_even <= 1'b1;
            frame_done   <= 1'b1;
            frame_ok     <= parity_ok;
            frame_data   <= shift_q;
            if (!parity_ok) begin
              if (clear_cnt) begin
                err_count <= ERR_CNT_W'(1);
              end else if (~&err_count) begin
                err_count <= err_count + ERR_CNT_W'(1);
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_frame_checker.sv
// Randomised self-checking bench for serial_parity_frame_checker; a wide-counter and a
// 2-bit-counter instance share the same stimulus.
module tb_serial_parity_frame_checker;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic odd_mode = 1'b0;
  logic clear_cnt = 1'b0;

  logic       busy, running_even, frame_done, frame_ok;
  logic [7:0] frame_data, err_count;
  logic       busy2, re2, done2, ok2;
  logic [7:0] data2;
  logic [1:0] cnt2;

  int n_checks = 0;
  int n_pass = 0;
  int exp_cnt8 = 0;
  int exp_cnt2 = 0;
  logic [8:0] re_obs, done_obs, busy_obs;

  always #5 clk = ~clk;

  serial_parity_frame_checker #(.DATA_BITS(8), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .odd_mode(odd_mode),
    .clear_cnt(clear_cnt), .busy(busy), .running_even(running_even),
    .frame_done(frame_done), .frame_ok(frame_ok), .frame_data(frame_data),
    .err_count(err_count)
  );

  serial_parity_frame_checker #(.DATA_BITS(8), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .odd_mode(odd_mode),
    .clear_cnt(clear_cnt), .busy(busy2), .running_even(re2),
    .frame_done(done2), .frame_ok(ok2), .frame_data(data2), .err_count(cnt2)
  );

  // Reference: a frame passes when its total ones count has the parity the mode asks for.
  function automatic logic model_ok(input logic [7:0] d, input logic p, input logic m);
    int ones;
    ones = $countones(d) + int'(p);
    return ((ones % 2) == 1) == m;
  endfunction

  function automatic logic [8:0] model_re(input logic [7:0] d);
    logic [8:0] r;
    int ones;
    ones = 0;
    for (int j = 0; j < 8; j++) begin
      ones += int'(d[j]);
      r[j] = (ones % 2) == 0;
    end
    r[8] = 1'b1;
    return r;
  endfunction

  task automatic model_count(input logic ok, input logic clr);
    if (clr) begin
      exp_cnt8 = ok ? 0 : 1;
      exp_cnt2 = ok ? 0 : 1;
    end else if (!ok) begin
      if (exp_cnt8 < 255) exp_cnt8++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
  endtask

  // Drives one full frame; records per-accepted-bit observations for the caller to check.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic m,
                            input int gapmax, input int flip_at, input logic clr_at_par);
    int g;
    for (int j = 0; j < 9; j++) begin
      g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      in_valid = 1'b0;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      if (j == 0) odd_mode = m;
      in_bit    = (j < 8) ? d[j] : p;
      clear_cnt = (j == 8) && clr_at_par;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      clear_cnt = 1'b0;
      if (j == flip_at) odd_mode = ~m;
      re_obs[j]   = running_even;
      done_obs[j] = frame_done;
      busy_obs[j] = busy;
    end
  endtask

  task automatic pulse_clear();
    clear_cnt = 1'b1;
    @(posedge clk);
    #1;
    clear_cnt = 1'b0;
    exp_cnt8 = 0;
    exp_cnt2 = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b1;
    in_bit = 1'b1;
    clear_cnt = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (running_even !== 1'b1) $display("FAIL reset running_even: got %b want 1", running_even);
    else n_pass++;
    n_checks++;
    if (frame_done !== 1'b0) $display("FAIL reset frame_done: got %b want 0", frame_done);
    else n_pass++;
    n_checks++;
    if (frame_ok !== 1'b0) $display("FAIL reset frame_ok: got %b want 0", frame_ok);
    else n_pass++;
    n_checks++;
    if (frame_data !== 8'h00) $display("FAIL reset frame_data: got %h want 00", frame_data);
    else n_pass++;
    n_checks++;
    if (err_count !== 8'd0) $display("FAIL reset err_count: got %0d want 0", err_count);
    else n_pass++;
    n_checks++;
    if ({busy2, re2, done2, ok2, data2, cnt2} !== {4'b0100, 8'h00, 2'd0})
      $display("FAIL reset dut2: got %b want %b", {busy2, re2, done2, ok2, data2, cnt2},
               {4'b0100, 8'h00, 2'd0});
    else n_pass++;
  endtask

  task automatic test_even_good();
    send_frame(8'hA5, 1'b0, 1'b0, 0, -1, 1'b0);
    model_count(model_ok(8'hA5, 1'b0, 1'b0), 1'b0);
    n_checks++;
    if (done_obs !== 9'h100) $display("FAIL even_good done: got %b want %b", done_obs, 9'h100);
    else n_pass++;
    n_checks++;
    if (frame_ok !== 1'b1) $display("FAIL even_good ok: got %b want 1", frame_ok); else n_pass++;
    n_checks++;
    if (frame_data !== 8'hA5) $display("FAIL even_good data: got %h want a5", frame_data);
    else n_pass++;
    n_checks++;
    if (err_count !== 8'(exp_cnt8))
      $display("FAIL even_good cnt: got %0d want %0d", err_count, exp_cnt8);
    else n_pass++;
    n_checks++;
    if (busy_obs !== 9'h0FF) $display("FAIL even_good busy: got %b want %b", busy_obs, 9'h0FF);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (frame_done !== 1'b0) $display("FAIL even_good pulse: got %b want 0", frame_done);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    send_frame(8'hA5, 1'b1, 1'b0, 0, -1, 1'b0);
    model_count(model_ok(8'hA5, 1'b1, 1'b0), 1'b0);
    n_checks++;
    if (frame_ok !== 1'b0) $display("FAIL b2b bad ok: got %b want 0", frame_ok); else n_pass++;
    n_checks++;
    if (err_count !== 8'(exp_cnt8))
      $display("FAIL b2b bad cnt: got %0d want %0d", err_count, exp_cnt8);
    else n_pass++;
    send_frame(8'h03, 1'b0, 1'b0, 0, -1, 1'b0);
    model_count(model_ok(8'h03, 1'b0, 1'b0), 1'b0);
    n_checks++;
    if (done_obs !== 9'h100) $display("FAIL b2b done: got %b want %b", done_obs, 9'h100);
    else n_pass++;
    n_checks++;
    if (frame_ok !== 1'b1) $display("FAIL b2b good ok: got %b want 1", frame_ok); else n_pass++;
    n_checks++;
    if (frame_data !== 8'h03) $display("FAIL b2b data: got %h want 03", frame_data);
    else n_pass++;
    n_checks++;
    if (err_count !== 8'(exp_cnt8))
      $display("FAIL b2b good cnt: got %0d want %0d", err_count, exp_cnt8);
    else n_pass++;
  endtask

  task automatic test_odd_mode();
    send_frame(8'h01, 1'b0, 1'b1, 0, 3, 1'b0);
    model_count(model_ok(8'h01, 1'b0, 1'b1), 1'b0);
    n_checks++;
    if (frame_ok !== 1'b1) $display("FAIL odd p0 ok: got %b want 1", frame_ok); else n_pass++;
    send_frame(8'h01, 1'b1, 1'b1, 0, 3, 1'b0);
    model_count(model_ok(8'h01, 1'b1, 1'b1), 1'b0);
    n_checks++;
    if (frame_ok !== 1'b0) $display("FAIL odd p1 ok: got %b want 0", frame_ok); else n_pass++;
    n_checks++;
    if (err_count !== 8'(exp_cnt8))
      $display("FAIL odd cnt: got %0d want %0d", err_count, exp_cnt8);
    else n_pass++;
  endtask

  task automatic test_gaps();
    send_frame(8'hF0, 1'b0, 1'b0, 5, -1, 1'b0);
    model_count(model_ok(8'hF0, 1'b0, 1'b0), 1'b0);
    n_checks++;
    if (frame_ok !== 1'b1) $display("FAIL gaps ok: got %b want 1", frame_ok); else n_pass++;
    n_checks++;
    if (frame_data !== 8'hF0) $display("FAIL gaps data: got %h want f0", frame_data);
    else n_pass++;
    n_checks++;
    if (re_obs !== 9'h1AF) $display("FAIL gaps running_even: got %b want %b", re_obs, 9'h1AF);
    else n_pass++;
  endtask

  task automatic test_saturation_clear();
    logic [7:0] d;
    logic p;
    pulse_clear();
    n_checks++;
    if ({err_count, cnt2} !== 10'd0) $display("FAIL sat clear0: got %0d/%0d want 0/0",
                                              err_count, cnt2);
    else n_pass++;
    for (int f = 0; f < 5; f++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      if (model_ok(d, p, 1'b0)) p = ~p;
      send_frame(d, p, 1'b0, 1, -1, 1'b0);
      model_count(1'b0, 1'b0);
      n_checks++;
      if (cnt2 !== 2'(exp_cnt2)) $display("FAIL sat cnt2[%0d]: got %0d want %0d", f, cnt2,
                                          exp_cnt2);
      else n_pass++;
      n_checks++;
      if (err_count !== 8'(exp_cnt8)) $display("FAIL sat cnt8[%0d]: got %0d want %0d", f,
                                               err_count, exp_cnt8);
      else n_pass++;
    end
    send_frame(8'h07, 1'b0, 1'b0, 0, -1, 1'b1);
    model_count(model_ok(8'h07, 1'b0, 1'b0), 1'b1);
    n_checks++;
    if ({err_count, cnt2} !== {8'(exp_cnt8), 2'(exp_cnt2)})
      $display("FAIL sat clear+fail: got %0d/%0d want %0d/%0d", err_count, cnt2, exp_cnt8,
               exp_cnt2);
    else n_pass++;
    pulse_clear();
    n_checks++;
    if ({err_count, cnt2} !== 10'd0) $display("FAIL sat clear1: got %0d/%0d want 0/0",
                                              err_count, cnt2);
    else n_pass++;
  endtask

  task automatic test_mid_frame_reset();
    send_frame(8'h01, 1'b0, 1'b0, 0, -1, 1'b0);
    model_count(model_ok(8'h01, 1'b0, 1'b0), 1'b0);
    odd_mode = 1'b0;
    for (int j = 0; j < 4; j++) begin
      in_bit = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (busy !== 1'b1) $display("FAIL midrst pre busy: got %b want 1", busy); else n_pass++;
    reset = 1'b0;
    clear_cnt = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    in_valid = 1'b0;
    clear_cnt = 1'b0;
    exp_cnt8 = 0;
    exp_cnt2 = 0;
    n_checks++;
    if ({busy, running_even, frame_done, frame_ok} !== 4'b0100)
      $display("FAIL midrst flags: got %b want 0100", {busy, running_even, frame_done, frame_ok});
    else n_pass++;
    n_checks++;
    if ({frame_data, err_count} !== 16'h0000)
      $display("FAIL midrst data/cnt: got %h/%0d want 00/0", frame_data, err_count);
    else n_pass++;
    send_frame(8'h5A, 1'b0, 1'b0, 0, -1, 1'b0);
    model_count(model_ok(8'h5A, 1'b0, 1'b0), 1'b0);
    n_checks++;
    if (done_obs !== 9'h100) $display("FAIL midrst done: got %b want %b", done_obs, 9'h100);
    else n_pass++;
    n_checks++;
    if (frame_ok !== 1'b1) $display("FAIL midrst ok: got %b want 1", frame_ok); else n_pass++;
    n_checks++;
    if (frame_data !== 8'h5A) $display("FAIL midrst data: got %h want 5a", frame_data);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic p, m, clr, ok;
    int flip;
    for (int f = 0; f < 40; f++) begin
      d    = 8'($urandom);
      p    = 1'($urandom);
      m    = 1'($urandom);
      clr  = ($urandom_range(7, 0) == 0);
      flip = int'($urandom_range(8, 0)) - 1;
      send_frame(d, p, m, 3, flip, clr);
      ok = model_ok(d, p, m);
      model_count(ok, clr);
      n_checks++;
      if (frame_ok !== ok) $display("FAIL rnd[%0d] ok: got %b want %b", f, frame_ok, ok);
      else n_pass++;
      n_checks++;
      if (ok2 !== ok) $display("FAIL rnd[%0d] ok2: got %b want %b", f, ok2, ok); else n_pass++;
      n_checks++;
      if (frame_data !== d) $display("FAIL rnd[%0d] data: got %h want %h", f, frame_data, d);
      else n_pass++;
      n_checks++;
      if (done_obs !== 9'h100) $display("FAIL rnd[%0d] done: got %b want %b", f, done_obs,
                                        9'h100);
      else n_pass++;
      n_checks++;
      if (re_obs !== model_re(d)) $display("FAIL rnd[%0d] running_even: got %b want %b", f,
                                           re_obs, model_re(d));
      else n_pass++;
      n_checks++;
      if (busy_obs !== 9'h0FF) $display("FAIL rnd[%0d] busy: got %b want %b", f, busy_obs,
                                        9'h0FF);
      else n_pass++;
      n_checks++;
      if (err_count !== 8'(exp_cnt8)) $display("FAIL rnd[%0d] cnt8: got %0d want %0d", f,
                                               err_count, exp_cnt8);
      else n_pass++;
      n_checks++;
      if (cnt2 !== 2'(exp_cnt2)) $display("FAIL rnd[%0d] cnt2: got %0d want %0d", f, cnt2,
                                          exp_cnt2);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_even_good();
    test_back_to_back();
    test_odd_mode();
    test_gaps();
    test_saturation_clear();
    test_mid_frame_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_parity_frame_checker.md
# serial_parity_frame_checker

Parametrised serial parity checker. It assembles a serial bit stream into frames of DATA_BITS data bits followed by one parity bit, checks each frame for even or odd parity, reports the result and the received data, and keeps a saturating error count. It is the framed, mode-selectable successor to the single-bit running even-parity detector, and sits directly behind a serial receive path.

## Interface
- DATA_BITS, 8: data bits per frame (≥1); each frame occupies DATA_BITS+1 accepted bits.
- ERR_CNT_W, 8: width of err_count (≥1).

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- in_valid  input  1  in_bit is accepted on any rising edge where in_valid=1.
- in_bit  input  1  serial data. Data bits arrive LSB first, then the parity bit.
- odd_mode  input  1  0 = even parity, 1 = odd parity. Sampled only on the first data bit of each frame.
- clear_cnt  input  1  synchronous clear of err_count.
- busy  output  1  1 while a frame is partially received (state DATA or PAR).
- running_even  output  1  1 when the number of ones accepted so far in the current frame is even.
- frame_done  output  1  one-cycle pulse when a frame's parity bit has been checked.
- frame_ok  output  1  parity result of the last completed frame; held until the next frame_done.
- frame_data  output  DATA_BITS  data bits of the last completed frame; held until the next frame_done.
- err_count  output  ERR_CNT_W  number of failed frames; saturates at 2^ERR_CNT_W−1.

## Operation
- FSM states:
  - IDLE: no frame in progress.
  - DATA: collecting data bits.
  - PAR: next accepted bit is the parity bit.
- FSM transitions, all qualified by in_valid=1. While in_valid=0, all state holds.
  - IDLE → DATA on the first data bit. odd_mode is latched on this bit.
  - If DATA_BITS=1, IDLE → PAR directly.
  - DATA → PAR when the DATA_BITS-th data bit is accepted.
  - PAR → IDLE when the parity bit is accepted.
- Bit counter:
  - Width is $clog2(DATA_BITS+1).
  - Counts accepted data bits and returns to 0 when a frame closes.
- Data shift register:
  - Data bit i, counted from 0 in arrival order, lands in frame_data bit i.
- running_even:
  - Toggles on every accepted 1, including the parity bit.
  - Returns to 1 on the edge that accepts the parity bit.
- Frame check:
  - ones = (ones in the data bits) + parity bit.
  - Even mode: frame_ok = (ones even).
  - Odd mode: frame_ok = (ones odd).
  - The mode used is the value latched for that frame. Changing odd_mode mid-frame has no effect on that frame.
- err_count:
  - Increments by 1 for each frame with frame_ok=0, unless already at its maximum value.
  - clear_cnt=1 forces 0.
  - clear_cnt together with a failing frame on the same edge gives 1.
- Reset (reset=0), in any state and including mid-frame:
  - FSM goes to IDLE and the bit counter to 0.
  - busy=0, running_even=1, frame_done=0, frame_ok=0, frame_data=0, err_count=0.
  - A partial frame is discarded: no frame_done pulse and no count change.
  - reset=0 takes priority over in_valid and clear_cnt.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Parity bit accepted at edge k:
  - frame_done=1 from edge k to edge k+1.
  - frame_ok, frame_data and err_count are updated at edge k.
- Back-to-back frames:
  - The first data bit of the next frame may be accepted at edge k+1, with no idle cycle.
  - With in_valid held high, frame_done pulses every DATA_BITS+1 cycles.
- busy:
  - Rises at the edge that accepts the first data bit.
  - Falls at edge k.
- Latency from the parity bit to the result is 1 edge. Throughput is 1 bit per cycle.
- in_valid gaps of any length inside a frame do not change the result.

## Test plan
All scenarios use DATA_BITS=8 unless noted.

1. Even mode, data 0xA5 (1,0,1,0,0,1,0,1), parity 0, in_valid held high → single frame_done pulse, frame_ok=1, frame_data=8'hA5, err_count=0, busy=0 after the frame.
2. Even mode, data 0xA5, parity 1 → frame_ok=0, err_count=1. Follow with an immediate good frame 0x03 with parity 0 → second frame_done exactly 9 cycles later, frame_ok=1, frame_data=8'h03, err_count stays 1.
3. odd_mode=1 at the first bit, data 0x01, parity 0, with odd_mode driven to 0 after bit 3 → frame_ok=1. Repeat with parity 1 → frame_ok=0.
4. Frame 0xF0 with parity 0 and random in_valid gaps of 0–5 cycles → frame_ok=1, frame_data=8'hF0. running_even sequence after each accepted bit: 1,1,1,1,0,1,0,1, then 1 after the parity bit.
5. ERR_CNT_W=2, five failing frames → err_count goes 1,2,3,3,3. Then clear_cnt=1 on the edge a failing frame completes → err_count=1. Then clear_cnt alone → 0.
6. reset=0 for one cycle after 4 data bits → busy=0, running_even=1, no frame_done, counts unchanged from reset values. The next complete frame 0x5A with parity 0 → frame_ok=1, frame_data=8'h5A.
